// File: rtl/uart_target_rx.sv
// uart_target_rx: 8N1 receiver that hunts for a sync byte, collects a 16-byte MD5 target
// digest plus XOR checksum, and presents the digest to the comparator on a valid checksum.
module uart_target_rx #(
    parameter int         CLKS_PER_BIT = 434,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5,
    parameter int         TIMEOUT_BITS = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         rx,
    output logic [0:127] target,
    output logic         target_valid,
    output logic         loaded,
    output logic         frame_err,
    output logic         rx_led
);
    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam int LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int CW    = $clog2(CLKS_PER_BIT + 1);
    localparam int TW    = $clog2(LIMIT + 1);
    localparam logic [1:0] B_IDLE  = 2'd0;
    localparam logic [1:0] B_START = 2'd1;
    localparam logic [1:0] B_DATA  = 2'd2;
    localparam logic [1:0] B_STOP  = 2'd3;
    localparam logic [1:0] P_HUNT  = 2'd0;
    localparam logic [1:0] P_HASH  = 2'd1;
    localparam logic [1:0] P_CSUM  = 2'd2;

    logic          r_rx_s1;
    logic          r_rx_s2;
    logic [1:0]    r_bstate;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bitn;
    logic [7:0]    r_shift;
    logic          r_byte_ok;
    logic          r_stop_err;
    logic [1:0]    r_pstate;
    logic [3:0]    r_idx;
    logic [7:0]    r_csum;
    logic [0:127]  r_buf;
    logic [TW-1:0] r_tmo;
    logic          r_commit;
    logic          w_rx;
    logic          w_tick_half;
    logic          w_tick_bit;
    logic          w_waiting;
    logic          w_timeout;

    assign w_rx        = r_rx_s2;
    assign w_tick_half = r_cnt == CW'(HALF - 1);
    assign w_tick_bit  = r_cnt == CW'(CLKS_PER_BIT - 1);
    assign w_waiting   = (r_pstate != P_HUNT) && (r_bstate == B_IDLE);
    assign w_timeout   = w_waiting && (r_tmo == TW'(LIMIT - 1));
    assign rx_led      = r_bstate != B_IDLE;

    // Bit engine: mid-bit sampling of the synchronised line, one byte_ok or stop_err pulse per frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_s1    <= 1'b1;
            r_rx_s2    <= 1'b1;
            r_bstate   <= B_IDLE;
            r_cnt      <= '0;
            r_bitn     <= '0;
            r_shift    <= '0;
            r_byte_ok  <= 1'b0;
            r_stop_err <= 1'b0;
        end else begin
            r_rx_s1    <= rx;
            r_rx_s2    <= r_rx_s1;
            r_byte_ok  <= 1'b0;
            r_stop_err <= 1'b0;
            r_cnt      <= r_cnt + 1'b1;
            case (r_bstate)
                B_IDLE: begin
                    r_cnt <= '0;
                    if (!w_rx) r_bstate <= B_START;
                end
                B_START: if (w_tick_half) begin
                    r_cnt    <= '0;
                    r_bitn   <= '0;
                    r_bstate <= w_rx ? B_IDLE : B_DATA;
                end
                B_DATA: if (w_tick_bit) begin
                    r_cnt   <= '0;
                    r_shift <= {w_rx, r_shift[7:1]};
                    r_bitn  <= r_bitn + 1'b1;
                    if (r_bitn == 3'd7) r_bstate <= B_STOP;
                end
                default: if (w_tick_bit) begin
                    r_cnt      <= '0;
                    r_byte_ok  <= w_rx;
                    r_stop_err <= !w_rx;
                    r_bstate   <= B_IDLE;
                end
            endcase
        end
    end

    // Frame parser: all error causes funnel into one registered pulse so they never stack
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pstate     <= P_HUNT;
            r_idx        <= '0;
            r_csum       <= '0;
            r_buf        <= '0;
            r_tmo        <= '0;
            r_commit     <= 1'b0;
            target       <= '0;
            target_valid <= 1'b0;
            loaded       <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            r_commit     <= 1'b0;
            target_valid <= r_commit;
            frame_err    <= 1'b0;
            r_tmo        <= w_waiting ? r_tmo + 1'b1 : '0;
            if (r_commit) begin
                target <= r_buf;
                loaded <= 1'b1;
            end
            if (r_stop_err) begin
                frame_err <= 1'b1;
                r_pstate  <= P_HUNT;
            end else if (r_byte_ok) begin
                case (r_pstate)
                    P_HUNT: if (r_shift == SYNC_BYTE) begin
                        r_pstate <= P_HASH;
                        r_idx    <= '0;
                        r_csum   <= '0;
                    end
                    P_HASH: begin
                        r_buf[8*r_idx +: 8] <= r_shift;
                        r_csum              <= r_csum ^ r_shift;
                        r_idx               <= r_idx + 1'b1;
                        if (r_idx == 4'd15) r_pstate <= P_CSUM;
                    end
                    default: begin
                        r_commit  <= r_shift == r_csum;
                        frame_err <= r_shift != r_csum;
                        r_pstate  <= P_HUNT;
                    end
                endcase
            end else if (w_timeout) begin
                frame_err <= 1'b1;
                r_pstate  <= P_HUNT;
            end
        end
    end
endmodule

// File: tb/tb_uart_target_rx.sv
// tb_uart_target_rx: drives 8N1 frames into uart_target_rx and checks accepted digests,
// error pulses and strobe timing against a frame-level model of the protocol.
module tb_uart_target_rx;
    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;
    localparam int TOB  = 32;

    typedef struct {
        logic [127:0] d;
        logic [23:0]  lead;
        int           nlead;
        logic         flip;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         rx = 1'b1;
    logic [0:127] target;
    logic         target_valid;
    logic         loaded;
    logic         frame_err;
    logic         rx_led;

    int           checks = 0;
    int           failures = 0;
    int           cyc = 0;
    int           n_valid = 0;
    int           n_err = 0;
    int           last_valid_cyc = -1;
    int           last_start = 0;
    logic         led_seen = 1'b0;
    logic [127:0] exp_tgt = '0;
    logic         exp_loaded = 1'b0;
    logic [127:0] tp_d = 128'h82cf9fa647dd1b3fbd9de71bbfb83fb2;

    uart_target_rx #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5), .TIMEOUT_BITS(TOB)) dut (
        .clk(clk), .reset(reset), .rx(rx), .target(target), .target_valid(target_valid),
        .loaded(loaded), .frame_err(frame_err), .rx_led(rx_led)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (target_valid) begin
            n_valid++;
            last_valid_cyc = cyc;
        end
        if (frame_err) n_err++;
    end

    function automatic logic [7:0] xsum(input logic [127:0] d);
        logic [7:0] s = '0;
        for (int i = 0; i < 16; i++) s ^= d[127-8*i -: 8];
        return s;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic bit_out(input logic v, input int n);
        rx = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_v);
        last_start = cyc;
        bit_out(1'b0, CPB);
        for (int i = 0; i < 8; i++) begin
            bit_out(b[i], CPB);
            if (i == 3) led_seen = led_seen | rx_led;
        end
        bit_out(stop_v, CPB);
        if (!stop_v) bit_out(1'b1, 2 * CPB);
    endtask

    task automatic send_frame(input logic [127:0] d, input logic [7:0] ck, input int bad_idx);
        send_byte(8'hA5, 1'b1);
        for (int i = 0; i < 16; i++) send_byte(d[127-8*i -: 8], i != bad_idx);
        send_byte(ck, 1'b1);
    endtask

    // Frame-level model: a frame is accepted only if every stop bit is good and ck is the XOR of the digest
    task automatic run_frame(input string name, input logic [127:0] d, input logic [7:0] ck,
                             input int bad_idx, input logic [23:0] lead, input int nlead);
        int   nv;
        int   ne;
        logic good;
        nv = n_valid;
        ne = n_err;
        good = (bad_idx < 0) && (ck == xsum(d));
        for (int i = 0; i < nlead; i++) send_byte(lead[8*i +: 8], 1'b1);
        send_frame(d, ck, bad_idx);
        bit_out(1'b1, 4 * CPB);
        if (good) begin
            exp_tgt = d;
            exp_loaded = 1'b1;
        end
        chk({name, "_valid_cycles"}, 128'(n_valid - nv), 128'(good ? 1 : 0));
        chk({name, "_err_cycles"}, 128'(n_err - ne), 128'(good ? 0 : 1));
        chk({name, "_target"}, target, exp_tgt);
        chk({name, "_loaded"}, 128'(loaded), 128'(exp_loaded));
    endtask

    initial begin
        vec_t         tbl[4];
        logic [127:0] d;
        logic [23:0]  lead;
        logic [7:0]   lb;
        int           nv;
        int           ne;
        tbl[0] = '{128'h0123456789abcdef0011223344556677, 24'h0, 0, 1'b0};
        tbl[1] = '{128'hffffffffffffffffffffffffffffffff, 24'h00003c, 1, 1'b1};
        tbl[2] = '{128'ha5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a5, 24'h005ac3, 2, 1'b0};
        tbl[3] = '{128'h0, 24'h0, 0, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_target", target, '0);
        chk("rst_valid", 128'(target_valid), 0);
        chk("rst_loaded", 128'(loaded), 0);
        chk("rst_err", 128'(frame_err), 0);
        chk("rst_led", 128'(rx_led), 0);
        reset = 1'b0;
        bit_out(1'b1, 2 * CPB);

        run_frame("bad_csum", tp_d, 8'h9d, -1, '0, 0);
        run_frame("good", tp_d, 8'h9c, -1, '0, 0);
        chk("latency", 128'(last_valid_cyc - last_start), 128'(5 + HALF + 9 * CPB));
        chk("rx_led_busy", 128'(led_seen), 1);
        chk("rx_led_idle", 128'(rx_led), 0);

        run_frame("noise", 128'h00112233445566778899aabbccddeeff, 8'h00 ^ xsum(128'h00112233445566778899aabbccddeeff),
                  -1, 24'h5aff00, 3);

        nv = n_valid;
        ne = n_err;
        bit_out(1'b0, 5);
        bit_out(1'b1, 4 * CPB);
        chk("glitch_valid", 128'(n_valid - nv), 0);
        chk("glitch_err", 128'(n_err - ne), 0);
        chk("glitch_led", 128'(rx_led), 0);

        run_frame("bad_stop", tp_d, 8'h9c, 7, '0, 0);

        nv = n_valid;
        ne = n_err;
        send_byte(8'hA5, 1'b1);
        for (int i = 0; i < 5; i++) send_byte(tp_d[127-8*i -: 8], 1'b1);
        bit_out(1'b1, 40 * CPB);
        chk("timeout_err", 128'(n_err - ne), 1);
        chk("timeout_valid", 128'(n_valid - nv), 0);
        chk("timeout_target", target, exp_tgt);
        run_frame("after_timeout", tp_d, 8'h9c, -1, '0, 0);

        for (int v = 0; v < 4; v++)
            run_frame($sformatf("tbl%0d", v), tbl[v].d, xsum(tbl[v].d) ^ {7'b0, tbl[v].flip},
                      -1, tbl[v].lead, tbl[v].nlead);

        for (int r = 0; r < 5; r++) begin
            d = {$urandom(), $urandom(), $urandom(), $urandom()};
            for (int i = 0; i < 3; i++) begin
                lb = 8'($urandom_range(0, 255));
                lead[8*i +: 8] = (lb == 8'hA5) ? 8'h00 : lb;
            end
            run_frame($sformatf("rnd%0d", r), d, xsum(d) ^ 8'($urandom_range(0, 1)),
                      -1, lead, $urandom_range(0, 2));
        end

        nv = n_valid;
        d = 128'hfedcba98765432100f1e2d3c4b5a6978;
        send_frame(tp_d, xsum(tp_d), -1);
        send_frame(d, xsum(d), -1);
        bit_out(1'b1, 4 * CPB);
        exp_tgt = d;
        chk("b2b_valid_cycles", 128'(n_valid - nv), 2);
        chk("b2b_target", target, exp_tgt);

        send_byte(8'hA5, 1'b1);
        for (int i = 0; i < 10; i++) send_byte(tp_d[127-8*i -: 8], 1'b1);
        bit_out(1'b0, CPB);
        bit_out(1'b1, 3 * CPB);
        reset = 1'b1;
        #1;
        chk("midrst_target", target, '0);
        chk("midrst_valid", 128'(target_valid), 0);
        chk("midrst_loaded", 128'(loaded), 0);
        chk("midrst_err", 128'(frame_err), 0);
        chk("midrst_led", 128'(rx_led), 0);
        exp_tgt = '0;
        exp_loaded = 1'b0;
        rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        bit_out(1'b1, 2 * CPB);
        run_frame("after_reset", tp_d, 8'h9c, -1, '0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_target_rx.md
Name: uart_target_rx

Overview:
- Serial receiver for the brute-force MD5 generator; the receive-side counterpart of the usart transmitter.
- Deserialises 8N1 UART frames on rx, hunts for a sync byte, then collects a 16-byte MD5 target digest and a 1-byte XOR checksum.
- On a valid checksum it presents the 128-bit target to the generator's comparator with a one-cycle strobe.
- Replaces the hard-coded target constant in the generator.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); must be >= 4.
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_BITS, 32, maximum idle gap in bit periods between bytes of one frame before the frame is abandoned.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous active-high reset
- rx  input  1  UART serial input, idle high, asynchronous to clk
- target  output  [0:127]  last accepted digest; byte 0 of the frame lands in target[0:7]
- target_valid  output  1  one-cycle pulse when target is updated
- loaded  output  1  level; high once any target has been accepted since reset
- frame_err  output  1  one-cycle pulse on bad stop bit, checksum mismatch or inter-byte timeout
- rx_led  output  1  high while a UART byte is being received (start bit through stop bit)

Behaviour:
- Reset (asynchronous, active-high): all outputs 0, target = 0, parser in HUNT, bit engine in IDLE, synchroniser flops set to 1.
- Reset asserted mid-frame discards the partial frame; target keeps its reset value of 0.
- rx passes through a 2-flop synchroniser before use. All timing below refers to the synchronised signal.
- Bit engine states and transitions:
  - IDLE: waits for synced rx = 0, then enters START.
  - START: counts CLKS_PER_BIT/2 cycles (integer division), then re-samples. If rx = 1 it is a false start: return to IDLE with no error. Otherwise enter DATA.
  - DATA: samples every CLKS_PER_BIT cycles, 8 samples, LSB first, into a shift register.
  - STOP: samples once after a further CLKS_PER_BIT cycles. rx = 1 gives byte_ok for one cycle; rx = 0 gives frame_err and the parser returns to HUNT. Either way, return to IDLE.
- rx_led is high from entry to START through exit from STOP.
- Parser states and transitions (advance only on byte_ok):
  - HUNT: a byte equal to SYNC_BYTE enters HASH with idx = 0 and csum = 0. Any other byte is ignored silently.
  - HASH: stores the byte into buf[8*idx +: 8] in [0:127] order, csum ^= byte, idx += 1. After idx 15, enter CSUM.
  - CSUM: if the received byte equals csum, on the next cycle target <= buf, target_valid = 1 and loaded = 1. Otherwise frame_err = 1 and target is unchanged. Either way, return to HUNT.
- SYNC_BYTE inside HASH or CSUM is treated as data, not as a resync.
- Timeout: while in HASH or CSUM with the bit engine in IDLE, a counter increments each cycle and clears on every START entry. Reaching TIMEOUT_BITS*CLKS_PER_BIT gives frame_err and a return to HUNT.
- frame_err sources are mutually exclusive per cycle; multiple causes never stack into a 2-cycle pulse.
- target holds its value between frames. A partial or bad frame never modifies target.
- loaded stays high until reset.
- Latency: target_valid asserts 2 clk cycles after the checksum byte's stop-bit sample.
- rx tolerance: sampling at mid-bit gives ±4% baud mismatch tolerance; no other filtering.

Test Plan:
- Send A5, then 82 cf 9f a6 47 dd 1b 3f bd 9d e7 1b bf b8 3f b2, then 9c -> target = 128'h82cf9fa647dd1b3fbd9de71bbfb83fb2, target_valid pulses exactly 1 cycle, loaded = 1, no frame_err.
- Same frame with checksum 9d -> frame_err pulse, target stays 0, loaded stays 0. An immediately following good frame is accepted.
- Noise bytes 00 FF 5A before A5 + valid frame -> leading bytes ignored, frame accepted. A 0.3-bit low glitch on idle rx -> no byte, no error.
- Frame byte 7 sent with stop bit 0 -> frame_err at that stop sample. The remaining bytes are hunted as non-sync and ignored; target unchanged.
- A5 plus 5 hash bytes, then line idle for 40 bit periods -> frame_err after 32 bit periods, parser in HUNT. A following complete frame is accepted.
- Assert reset during hash byte 10 of a frame -> all outputs 0 immediately. After release, a fresh full frame is accepted. Two back-to-back good frames with different digests -> two target_valid pulses, target equals the second digest.
